// File: rtl/prv32_div_seq.sv
// Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle, with a start/busy/done handshake for the hazard unit.
module prv32_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] r,
  output logic [4:0]  rd_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  tag_q, tag_d;
  logic [4:0]  rd_q, rd_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic [31:0] quo_q, quo_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] div_q, div_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] r_q, r_d;

  logic        is_signed, a_neg, b_neg, ovf, accept;
  logic [31:0] a_mag, b_mag, q_fix, rm_fix;
  logic [32:0] rem_sh;
  logic [33:0] diff;

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & a[31];
    b_neg     = is_signed & b[31];
    a_mag     = a_neg ? (32'd0 - a) : a;
    b_mag     = b_neg ? (32'd0 - b) : b;
    ovf       = is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    rem_sh    = {rem_q[31:0], quo_q[31]};
    diff      = {1'b0, rem_sh} - {2'b00, div_q};
    // Unsigned ops record zero signs, so these corrections are no-ops for them.
    q_fix     = (sa_q ^ sb_q) ? (32'd0 - quo_q) : quo_q;
    rm_fix    = sa_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];

    state_d = state_q;
    op_d    = op_q;
    tag_d   = tag_q;
    rd_d    = rd_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    r_d     = r_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (accept) begin
            op_d  = op;
            tag_d = rd_in;
            sa_d  = a_neg;
            sb_d  = b_neg;
            quo_d = a_mag;
            div_d = b_mag;
            rem_d = '0;
            cnt_d = '0;
            if (b == 32'd0) begin
              r_d     = op[1] ? a : '1;
              rd_d    = rd_in;
              state_d = S_DONE;
            end else if (ovf) begin
              r_d     = op[1] ? 32'd0 : 32'h8000_0000;
              rd_d    = rd_in;
              state_d = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          if (!diff[33]) begin
            rem_d = diff[32:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = rem_sh;
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_FIX;
        end
        S_FIX: begin
          r_d     = op_q[1] ? rm_fix : q_fix;
          rd_d    = tag_q;
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      tag_q   <= '0;
      rd_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      rd_q    <= rd_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
    end
  end

  assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done   = (state_q == S_DONE);
  assign r      = r_q;
  assign rd_out = rd_q;

endmodule
